rr_fu_arbiter: RTL and testbench
================================

# rr_fu_arbiter

Round-robin issue arbiter that shares one multi-cycle functional unit (e.g. multiplier/divider) among `WIDTH` requesting issue slots. It selects one requester per free slot of the unit using a rotating-priority pick built on lowest-index priority encoding. It tracks occupancy of the unit for `LATENCY` cycles and reports completion with the owner's index. It supports a synchronous pipeline flush that aborts in-flight work.

## Interface
- `WIDTH`, 6: number of requesters (≥2).
- `LATENCY`, 4: cycles from grant to completion (≥1).
- `IDX_W`, `$clog2(WIDTH)`: derived index width; not overridden.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  WIDTH  level request per requester.
- `flush`  in  1  abort in-flight op, suppress grant this cycle.
- `gnt_valid`  out  1  grant issued this cycle.
- `gnt_idx`  out  IDX_W  granted requester index; 0 when `gnt_valid`=0.
- `gnt_onehot`  out  WIDTH  one-hot grant; all zero when `gnt_valid`=0.
- `busy`  out  1  unit occupied by a granted op.
- `done_valid`  out  1  completion pulse for in-flight op.
- `done_idx`  out  IDX_W  owner of completing op; 0 when `done_valid`=0.

## Operation
- State: `IDLE`/`BUSY`, down-counter `cnt` (width `$clog2(LATENCY+1)`), owner register `own`, priority pointer `ptr` (IDX_W).
- Reset: state `IDLE`, `cnt`=0, `own`=0, `ptr`=0. All outputs 0.
- Free slot (`slot_free`): state `IDLE`, or state `BUSY` with `cnt`==0 (completing this cycle).
- Pick: `masked = req & ~((1<<ptr)-1)`. If `masked`≠0, pick its lowest set bit, else the lowest set bit of `req`.
  - Effective priority order is `ptr`, `ptr+1`, …, `WIDTH-1`, 0, …, `ptr-1`.
- Grant (combinational): `gnt_valid = slot_free & |req & ~flush`. `gnt_idx`/`gnt_onehot` carry the pick, else 0.
- On grant edge:
  - state→`BUSY`, `cnt`←`LATENCY-1`, `own`←pick.
  - `ptr`←pick+1, wrapping `WIDTH-1`→0. Arithmetic is mod `WIDTH`, not mod 2^IDX_W.
- `BUSY` with `cnt`>0: `cnt` decrements each cycle.
- `BUSY` with `cnt`==0:
  - `done_valid`=1, `done_idx`=`own`.
  - Next state is `BUSY` if a grant occurs this cycle, else `IDLE`.
- `busy` = (state==`BUSY`).
- Flush cycle:
  - `gnt_valid`=0 and `done_valid`=0.
  - state→`IDLE`, `cnt`→0, `ptr` unchanged, `own` unchanged (don't-care).
- Requester contract:
  - A requester whose `req` is high in a `gnt_valid` cycle for its index deasserts or re-requests next cycle.
  - The arbiter does not track requests; a held `req` competes again at the next free slot.
- `rst` dominates `flush` and grant.

## Timing
- Grant latency: 0 cycles. `req` high in cycle T with a free slot gives `gnt_valid` in T.
- Grant in T: `busy`=1 in T+1…T+LATENCY, `done_valid`=1 in T+LATENCY.
- Back-to-back: next grant is allowed in T+LATENCY, the same cycle as `done_valid`. Peak rate is one grant per `LATENCY` cycles.
- `LATENCY`=1: grant every cycle possible. `busy` stays high continuously while `req`≠0. `done_valid` in T+1.
- No requests while `IDLE`: all outputs 0, no state change.
- Flush in cycle F: `busy`=0 from F+1. The earliest new grant is F+1.
- `rst` in cycle R: outputs return to reset values in R+1. Any in-flight op is dropped without `done_valid`.

## Test plan
- **Reset:** assert `rst` 2 cycles with `req`=6'b111111 → every output 0 in the cycle after reset is applied, `ptr`=0.
- **Single op** (`LATENCY`=4): `req`=6'b001000 for one cycle at T=0 →
  - `gnt_valid`=1, `gnt_idx`=3, `gnt_onehot`=6'b001000 at T=0.
  - `busy`=1 at T=1..4, `done_valid`=1 with `done_idx`=3 at T=4.
  - `busy`=0 at T=5.
- **Fairness:** `req`=6'b111111 held → grants at T=0,4,8,12,16,20,24 with idx 0,1,2,3,4,5,0. Each `done_valid` coincides with the next grant.
- **Wrap:** drive `ptr` to 4 by granting idx 3, then `req`=6'b000011 → grant idx 0 (wrap). Next slot with same `req` → idx 1, then 0.
- **Flush:** grant idx 2 at T=0, `flush`=1 at T=2 →
  - no `done_valid` at T=4, `busy`=0 from T=3.
  - with `req`=6'b000100 held from T=3, regrant idx 2 at T=3.
- **Flush with request:** `flush`=1 and `req`=6'b000010 in `IDLE` → `gnt_valid`=0 and `ptr` unchanged. Next cycle without flush → grant idx 1.

Source files
------------

// File: rtl/rr_fu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle functional unit among WIDTH issue slots.
// Tracks unit occupancy for LATENCY cycles and reports completion with the owner index.
module rr_fu_arbiter #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             flush,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [WIDTH-1:0] gnt_onehot,
    output logic             busy,
    output logic             done_valid,
    output logic [IDX_W-1:0] done_idx
);

    localparam int unsigned CntW = $clog2(LATENCY + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]  own_q, own_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [WIDTH-1:0]  masked;
    logic [IDX_W-1:0]  pick_m, pick_r, pick, ptr_nxt;
    logic              slot_free;

    // Requests at or above the pointer win; otherwise fall back to the lowest request.
    always_comb begin
        masked = '0;
        pick_m = '0;
        pick_r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            masked[i] = req[i] & (i >= int'(ptr_q));
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (masked[i]) pick_m = IDX_W'(i);
            if (req[i])    pick_r = IDX_W'(i);
        end
        pick    = (|masked) ? pick_m : pick_r;
        ptr_nxt = (pick == IDX_W'(WIDTH - 1)) ? '0 : pick + IDX_W'(1);
    end

    assign slot_free  = (state_q == StIdle) || (cnt_q == '0);
    assign gnt_valid  = ~rst & slot_free & (|req) & ~flush;
    assign gnt_idx    = gnt_valid ? pick : '0;
    assign gnt_onehot = gnt_valid ? (WIDTH'(1) << pick) : '0;
    assign busy       = (state_q == StBusy);
    assign done_valid = ~rst & ~flush & busy & (cnt_q == '0);
    assign done_idx   = done_valid ? own_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (gnt_valid) begin
            state_d = StBusy;
            cnt_d   = CntW'(LATENCY - 1);
            own_d   = pick;
            ptr_d   = ptr_nxt;
        end else if (state_q == StBusy) begin
            if (cnt_q == '0) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_fu_arbiter.sv
// Directed bench for rr_fu_arbiter: a per-cycle vector table on a LATENCY=4 instance,
// plus a held-request fairness sequence checked on LATENCY=4 and LATENCY=1 instances.
module tb_rr_fu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [5:0] req = '0;

    logic       g4_v, d4_v, b4, g1_v, d1_v, b1;
    logic [2:0] g4_idx, d4_idx, g1_idx, d1_idx;
    logic [5:0] g4_oh, g1_oh;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_fu_arbiter #(.WIDTH(6), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .flush(flush),
        .gnt_valid(g4_v), .gnt_idx(g4_idx), .gnt_onehot(g4_oh),
        .busy(b4), .done_valid(d4_v), .done_idx(d4_idx)
    );

    rr_fu_arbiter #(.WIDTH(6), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .flush(flush),
        .gnt_valid(g1_v), .gnt_idx(g1_idx), .gnt_onehot(g1_oh),
        .busy(b1), .done_valid(d1_v), .done_idx(d1_idx)
    );

    typedef struct {
        logic       chk;
        logic       rst;
        logic       flush;
        logic [5:0] req;
        logic       ev;
        logic [2:0] eidx;
        logic       ebusy;
        logic       edv;
        logic [2:0] edidx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic chk, logic r, logic f, logic [5:0] rq, logic ev,
                                logic [2:0] eidx, logic eb, logic edv, logic [2:0] edidx);
        vec_t v;
        v = '{chk: chk, rst: r, flush: f, req: rq, ev: ev, eidx: eidx, ebusy: eb,
              edv: edv, edidx: edidx};
        vecs.push_back(v);
    endfunction

    // Layout: {gnt_valid, gnt_idx, gnt_onehot, busy, done_valid, done_idx}
    function automatic logic [14:0] pack(logic v, logic [2:0] idx, logic b, logic dv,
                                         logic [2:0] di);
        logic [5:0] oh;
        oh = '0;
        if (v) oh[idx] = 1'b1;
        return {v, idx, oh, b, dv, di};
    endfunction

    task automatic check(input string nm, input int cyc, input logic [14:0] act,
                         input logic [14:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got {gv,idx,oh,busy,dv,didx}=%b want %b",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic busy_n(input int n, input logic [5:0] rq);
        for (int k = 0; k < n; k++) add(1, 0, 0, rq, 0, 0, 1, 0, 0);
    endtask

    initial begin
        // Reset with all requesters asserted
        add(0, 1, 0, 6'h3F, 0, 0, 0, 0, 0);
        add(1, 1, 0, 6'h3F, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Single op from idx 3, ptr -> 4
        add(1, 0, 0, 6'h08, 1, 3, 0, 0, 0);
        busy_n(3, 6'h00);
        add(1, 0, 0, 6'h00, 0, 0, 1, 1, 3);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Wrap: ptr 4 with req 000011 -> 0, 1, 0
        add(1, 0, 0, 6'h03, 1, 0, 0, 0, 0);
        busy_n(3, 6'h03);
        add(1, 0, 0, 6'h03, 1, 1, 1, 1, 0);
        busy_n(3, 6'h03);
        add(1, 0, 0, 6'h03, 1, 0, 1, 1, 1);
        busy_n(3, 6'h00);
        add(1, 0, 0, 6'h00, 0, 0, 1, 1, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Flush mid-op then immediate regrant of idx 2
        add(1, 0, 0, 6'h04, 1, 2, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 1, 0, 0);
        add(1, 0, 1, 6'h00, 0, 0, 1, 0, 0);
        add(1, 0, 0, 6'h04, 1, 2, 0, 0, 0);
        busy_n(3, 6'h00);
        add(1, 0, 0, 6'h00, 0, 0, 1, 1, 2);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Flush with no regrant: op dropped, no completion
        add(1, 0, 0, 6'h01, 1, 0, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 1, 0, 0);
        add(1, 0, 1, 6'h00, 0, 0, 1, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Flush with request while idle
        add(1, 0, 1, 6'h02, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6'h02, 1, 1, 0, 0, 0);
        busy_n(3, 6'h00);
        add(1, 0, 0, 6'h00, 0, 0, 1, 1, 1);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        // Reset mid-op: no completion, ptr back to 0
        add(1, 0, 0, 6'h01, 1, 0, 0, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 1, 0, 0);
        add(1, 1, 0, 6'h3F, 0, 0, 1, 0, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6'h3F, 1, 0, 0, 0, 0);
        busy_n(3, 6'h00);
        add(1, 0, 0, 6'h00, 0, 0, 1, 1, 0);
        add(1, 0, 0, 6'h00, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            flush = vecs[i].flush;
            req   = vecs[i].req;
            #1;
            if (vecs[i].chk) begin
                check("table", i, {g4_v, g4_idx, g4_oh, b4, d4_v, d4_idx},
                      pack(vecs[i].ev, vecs[i].eidx, vecs[i].ebusy, vecs[i].edv,
                           vecs[i].edidx));
            end
        end

        // Fairness with all requesters held, both latencies
        @(negedge clk);
        rst   = 1'b1;
        flush = 1'b0;
        req   = '0;
        for (int t = 0; t < 27; t++) begin
            logic [14:0] e4, e1;
            @(negedge clk);
            rst = 1'b0;
            req = (t < 25) ? 6'h3F : 6'h00;
            #1;
            if (t >= 25) begin
                e4 = pack(0, 0, 1, 0, 0);
                e1 = (t == 25) ? pack(0, 0, 1, 1, 3'(24 % 6)) : pack(0, 0, 0, 0, 0);
            end else begin
                if (t % 4 == 0) begin
                    e4 = (t == 0) ? pack(1, 0, 0, 0, 0)
                                  : pack(1, 3'((t / 4) % 6), 1, 1, 3'((t / 4 - 1) % 6));
                end else begin
                    e4 = pack(0, 0, 1, 0, 0);
                end
                e1 = (t == 0) ? pack(1, 0, 0, 0, 0)
                              : pack(1, 3'(t % 6), 1, 1, 3'((t - 1) % 6));
            end
            check("fair_lat4", t, {g4_v, g4_idx, g4_oh, b4, d4_v, d4_idx}, e4);
            check("fair_lat1", t, {g1_v, g1_idx, g1_oh, b1, d1_v, d1_idx}, e1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
